// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmit arbiter.
// State encoding, tag nibble and default timing parameters.
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GUARD     = 3'd4
    } state_t;

    localparam logic [3:0] TAG_NIBBLE    = 4'hA;
    localparam int         DEF_GUARD_CYC = 2;
    localparam int         DEF_BUSY_TO   = 4;

    function automatic logic [7:0] tag_byte(input logic [2:0] id);
        return {TAG_NIBBLE, 1'b0, id};
    endfunction

endpackage

// File: rtl/serial_tx_arbiter_rr.sv
// Combinational round-robin picker: first asserted req at or after ptr.
// Returns a onehot grant, its index and an any-request flag.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int unsigned j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Round-robin scheduler feeding one serial transmitter with guard spacing.
// Define SERIAL_TX_ARB_TAG_EN to prefix each byte with a requester tag frame.
module serial_tx_arbiter
    import serial_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int GUARD_CYC = DEF_GUARD_CYC,
    parameter int BUSY_TO   = DEF_BUSY_TO
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [8*NREQ-1:0]       data_in,
    output logic [NREQ-1:0]         ack,
    output logic [7:0]              byte_out,
    output logic                    start,
    input  logic                    ready_in,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    err
);

    localparam int IW = $clog2(NREQ);
    localparam int GW = $clog2(GUARD_CYC + 1);
    localparam int TW = $clog2(BUSY_TO + 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]      byte_q, byte_d;
    logic [IW-1:0]   gid_q, gid_d;
    logic [GW-1:0]   gcnt_q, gcnt_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            err_q, err_d;
    logic [NREQ-1:0] ack_c;
    logic [TW-1:0]   tcnt_inc;

    logic [NREQ-1:0] win_oh;
    logic [IW-1:0]   win_idx;
    logic            win_any;

`ifdef SERIAL_TX_ARB_TAG_EN
    logic            tag_q, tag_d;
    logic [7:0]      data_q, data_d;
    logic [2:0]      gid3;
`endif

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req   (req),
        .ptr   (rr_ptr_q),
        .grant (win_oh),
        .idx   (win_idx),
        .any   (win_any)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        byte_d   = byte_q;
        gid_d    = gid_q;
        gcnt_d   = gcnt_q;
        tcnt_d   = tcnt_q;
        err_d    = 1'b0;
        ack_c    = '0;
        tcnt_inc = tcnt_q + TW'(1);
`ifdef SERIAL_TX_ARB_TAG_EN
        tag_d    = tag_q;
        data_d   = data_q;
        gid3     = 3'(win_idx);
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    ack_c    = win_oh;
                    gid_d    = win_idx;
                    rr_ptr_d = (win_idx == IW'(NREQ - 1)) ?
                               '0 : win_idx + IW'(1);
`ifdef SERIAL_TX_ARB_TAG_EN
                    byte_d   = tag_byte(gid3);
                    data_d   = data_in[8*win_idx +: 8];
                    tag_d    = 1'b1;
`else
                    byte_d   = data_in[8*win_idx +: 8];
`endif
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                tcnt_d  = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!ready_in) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    tcnt_d = tcnt_inc;
                    // Timeout drops the frame (and any pending data byte).
                    if (tcnt_inc == TW'(BUSY_TO)) begin
                        err_d   = 1'b1;
                        gcnt_d  = GW'(GUARD_CYC);
                        state_d = ST_GUARD;
`ifdef SERIAL_TX_ARB_TAG_EN
                        tag_d   = 1'b0;
`endif
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (ready_in) begin
                    gcnt_d  = GW'(GUARD_CYC);
                    state_d = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (gcnt_q <= GW'(1)) begin
`ifdef SERIAL_TX_ARB_TAG_EN
                    if (tag_q) begin
                        byte_d  = data_q;
                        tag_d   = 1'b0;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    gcnt_d = gcnt_q - GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            byte_q   <= '0;
            gid_q    <= '0;
            gcnt_q   <= '0;
            tcnt_q   <= '0;
            err_q    <= 1'b0;
`ifdef SERIAL_TX_ARB_TAG_EN
            tag_q    <= 1'b0;
            data_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            byte_q   <= byte_d;
            gid_q    <= gid_d;
            gcnt_q   <= gcnt_d;
            tcnt_q   <= tcnt_d;
            err_q    <= err_d;
`ifdef SERIAL_TX_ARB_TAG_EN
            tag_q    <= tag_d;
            data_q   <= data_d;
`endif
        end
    end

    // No ack while reset is asserted: the grant would be discarded.
    assign ack      = reset ? ack_c : '0;
    assign start    = (state_q == ST_START);
    assign busy     = (state_q != ST_IDLE);
    assign byte_out = byte_q;
    assign grant_id = gid_q;
    assign err      = err_q;

endmodule
